// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI4 SRAM responder (axi_slv_ram).
// Byte-lane write gating is enabled by defining AXI_SLV_RAM_WSTRB_EN.
package axi_slv_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam logic [2:0] SIZE_FULL = 3'd4;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } rbeat_t;

  // Only full-width FIXED/INCR bursts are served; everything else errors.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != FIXED) && (burst != INCR)) || (size != SIZE_FULL);
  endfunction

endpackage

// File: rtl/axi_slv_ram_mem.sv
// Simple dual-port read-first SRAM with 1-cycle synchronous read.
// Byte enables take effect only when AXI_SLV_RAM_WSTRB_EN is defined.
module axi_slv_ram_mem
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wbe,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
`ifdef AXI_SLV_RAM_WSTRB_EN
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
`else
      r_mem[i_waddr] <= i_wdata;
`endif
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

`ifndef AXI_SLV_RAM_WSTRB_EN
  logic w_unused_be;
  assign w_unused_be = ^i_wbe;
`endif

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_slv_ram.sv
// AXI4 responder backed by on-chip SRAM; one read and one write burst in flight.
// Define AXI_SLV_RAM_WSTRB_EN to make wstrb gate RAM byte lanes.
module axi_slv_ram
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [63:0]       i_awaddr,
  input  logic [ID_W-1:0]   i_awid,
  input  logic [7:0]        i_awlen,
  input  logic [2:0]        i_awsize,
  input  logic [1:0]        i_awburst,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic              i_wlast,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [ID_W-1:0]   o_bid,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready,
  input  logic [63:0]       i_araddr,
  input  logic [ID_W-1:0]   i_arid,
  input  logic [7:0]        i_arlen,
  input  logic [2:0]        i_arsize,
  input  logic [1:0]        i_arburst,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ID_W-1:0]   o_rid,
  output logic [1:0]        o_rresp,
  output logic              o_rlast,
  output logic              o_rvalid,
  input  logic              i_rready
);

  localparam int unsigned IDX_W = ADDR_W + 1;

  wr_state_t        r_wstate, w_wstate_nxt;
  logic [ID_W-1:0]  r_bid;
  logic [7:0]       r_wlen;
  logic [8:0]       r_wcnt;
  logic [IDX_W-1:0] r_widx;
  logic             r_wfixed, r_werr;
  logic             w_aw_hs, w_w_hs, w_w_cnt_last, w_w_end, w_we;

  rd_state_t        r_rstate, w_rstate_nxt;
  logic [ID_W-1:0]  r_rid;
  logic [8:0]       r_rrem;
  logic [IDX_W-1:0] r_ridx;
  logic             r_rfixed, r_rerr;
  logic             r_rd_vld, r_rd_err, r_rd_last;
  rbeat_t           r_buf0, r_buf1, w_new;
  logic [1:0]       r_cnt;
  logic             w_ar_hs, w_ar_err, w_pop, w_room;
  logic             w_iss, w_iss_err, w_iss_last, w_iss_fixed;
  logic [IDX_W-1:0] w_iss_idx;
  logic [DATA_W-1:0] w_ram_q;

  // ---------------- write path ----------------
  always_comb begin
    w_aw_hs      = i_awvalid && (r_wstate == W_IDLE);
    w_w_hs       = i_wvalid && (r_wstate == W_DATA);
    w_w_cnt_last = (r_wcnt == {1'b0, r_wlen});
    w_w_end      = i_wlast || w_w_cnt_last;
    w_we         = w_w_hs && !r_werr && !r_widx[ADDR_W];
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_w_end) w_wstate_nxt = W_RESP;
      W_RESP:  if (i_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wstate <= W_IDLE;
      r_bid    <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_widx   <= '0;
      r_wfixed <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_bid    <= i_awid;
        r_wlen   <= i_awlen;
        r_wcnt   <= '0;
        r_widx   <= {1'b0, i_awaddr[4+ADDR_W-1:4]};
        r_wfixed <= (i_awburst == FIXED);
        r_werr   <= burst_bad(i_awburst, i_awsize) || (|i_awaddr[63:4+ADDR_W]);
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt + 9'd1;
        if (!r_wfixed) r_widx <= r_widx + IDX_W'(1);
        // Sticky: covers out-of-range beats and wlast disagreeing with awlen.
        if (r_widx[ADDR_W] || (i_wlast != w_w_cnt_last)) r_werr <= 1'b1;
      end
    end
  end

  assign o_awready = (r_wstate == W_IDLE);
  assign o_wready  = (r_wstate == W_DATA);
  assign o_bvalid  = (r_wstate == W_RESP);
  assign o_bid     = r_bid;
  assign o_bresp   = r_werr ? SLVERR : OKAY;

  // ---------------- read path ----------------
  always_comb begin
    w_ar_hs  = i_arvalid && (r_rstate == R_IDLE);
    w_ar_err = burst_bad(i_arburst, i_arsize) || (|i_araddr[63:4+ADDR_W]);
    w_pop    = (r_cnt != 2'd0) && i_rready;
    // Beats in the buffer plus the one in the RAM stage must fit in two slots.
    w_room   = ({1'b0, r_cnt} + {2'b0, r_rd_vld}) < (3'd2 + {2'b0, w_pop});
    if (w_ar_hs) begin
      w_iss       = 1'b1;
      w_iss_idx   = {1'b0, i_araddr[4+ADDR_W-1:4]};
      w_iss_err   = w_ar_err;
      w_iss_last  = (i_arlen == 8'd0);
      w_iss_fixed = (i_arburst == FIXED);
    end else begin
      w_iss       = (r_rstate == R_DATA) && (r_rrem != 9'd0) && w_room;
      w_iss_idx   = r_ridx;
      w_iss_err   = r_rerr || r_ridx[ADDR_W];
      w_iss_last  = (r_rrem == 9'd1);
      w_iss_fixed = r_rfixed;
    end
    w_new.data = r_rd_err ? '0 : w_ram_q;
    w_new.resp = r_rd_err ? SLVERR : OKAY;
    w_new.last = r_rd_last;
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_pop && r_buf0.last) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rstate  <= R_IDLE;
      r_rid     <= '0;
      r_rrem    <= '0;
      r_ridx    <= '0;
      r_rfixed  <= 1'b0;
      r_rerr    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_last <= 1'b0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_cnt     <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rd_vld <= w_iss;
      if (w_ar_hs) begin
        r_rid    <= i_arid;
        r_rrem   <= {1'b0, i_arlen};
        r_rfixed <= (i_arburst == FIXED);
        r_rerr   <= w_ar_err;
      end else if (w_iss) begin
        r_rrem <= r_rrem - 9'd1;
        r_rerr <= w_iss_err;
      end
      if (w_iss) begin
        r_rd_err  <= w_iss_err;
        r_rd_last <= w_iss_last;
        r_ridx    <= w_iss_fixed ? w_iss_idx : w_iss_idx + IDX_W'(1);
      end
      if (w_pop) r_buf0 <= r_buf1;
      if (r_rd_vld) begin
        if ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)) r_buf0 <= w_new;
        else r_buf1 <= w_new;
      end
      r_cnt <= r_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
    end
  end

  assign o_arready = (r_rstate == R_IDLE);
  assign o_rvalid  = (r_cnt != 2'd0);
  assign o_rdata   = r_buf0.data;
  assign o_rresp   = r_buf0.resp;
  assign o_rlast   = r_buf0.last;
  assign o_rid     = r_rid;

  logic w_unused_addr;
  assign w_unused_addr = ^{i_awaddr[3:0], i_araddr[3:0]};

  axi_slv_ram_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_widx[ADDR_W-1:0]),
    .i_wdata (i_wdata),
    .i_wbe   (i_wstrb),
    .i_re    (w_iss),
    .i_raddr (w_iss_idx[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_axi_slv_ram.sv
// Self-checking bench for axi_slv_ram: vector table plus read scoreboard queue.
module tb_axi_slv_ram;
  import axi_slv_pkg::*;

  localparam int CYC = 300;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] awaddr, araddr;
  logic [3:0] awid, arid, bid, rid;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [127:0] wdata, rdata;
  logic [15:0] wstrb;

  always #5 clk = ~clk;

  axi_slv_ram #(.ADDR_W(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_awaddr(awaddr), .i_awid(awid), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arid(arid), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rid(rid), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready)
  );

  int total = 0;
  int bad = 0;
  logic [127:0] mdl [1024];

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit           wr;
    logic [63:0]  addr;
    logic [7:0]   len;
    logic [3:0]   id;
    logic [1:0]   burst;
    logic [2:0]   size;
    logic [127:0] base;
    logic [15:0]  strb;
    int           nbeats;
    bit           toggle;
    logic [1:0]   bresp;
  } vec_t;
  vec_t vt [18];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] strb);
    logic [127:0] r;
    r = nw;
`ifdef AXI_SLV_RAM_WSTRB_EN
    for (int i = 0; i < 16; i++) r[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
`else
    if (strb == 16'h0) r = old ^ old ^ nw;
`endif
    return r;
  endfunction

  function automatic logic berr_of(input logic [63:0] a, input logic [1:0] b, input logic [2:0] s);
    return !(b == 2'b00 || b == 2'b01) || (s != 3'd4) || (a[63:14] != 50'd0);
  endfunction

  task automatic do_write(input vec_t v);
    logic berr;
    logic [10:0] idx;
    int n;
    berr = berr_of(v.addr, v.burst, v.size);
    idx = {1'b0, v.addr[13:4]};
    for (int b = 0; b < v.nbeats; b++) begin
      if (!berr && !idx[10]) mdl[idx[9:0]] = merge(mdl[idx[9:0]], v.base + 128'(b), v.strb);
      if (v.burst == 2'b01) idx++;
    end
    awaddr = v.addr; awid = v.id; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < CYC) begin @(negedge clk); n++; end
    check("aw_wait", 128'(n < CYC), 128'(1));
    @(negedge clk);
    awvalid = 1'b0;
    check("wready_after_aw", 128'(wready), 128'(1));
    for (int b = 0; b < v.nbeats; b++) begin
      wdata = v.base + 128'(b); wstrb = v.strb; wlast = (b == v.nbeats - 1); wvalid = 1'b1;
      n = 0;
      while (!wready && n < CYC) begin @(negedge clk); n++; end
      if (n >= CYC) check("w_wait", 128'(0), 128'(1));
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_lat", 128'(bvalid), 128'(1));
    check("bid", 128'(bid), 128'(v.id));
    check("bresp", 128'(bresp), 128'(v.bresp));
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < CYC) begin @(negedge clk); n++; end
    @(negedge clk);
    bready = 1'b0;
    check("awready_after_b", 128'(awready), 128'(1));
    check("bvalid_drop", 128'(bvalid), 128'(0));
  endtask

  task automatic do_read(input vec_t v);
    logic berr, first, stall;
    logic [10:0] idx;
    exp_t e;
    int n, lat, got;
    logic [127:0] s_data;
    logic [7:0] s_ctl;
    berr = berr_of(v.addr, v.burst, v.size);
    idx = {1'b0, v.addr[13:4]};
    for (int b = 0; b <= int'(v.len); b++) begin
      e.resp = (berr || idx[10]) ? 2'b10 : 2'b00;
      e.data = (e.resp == 2'b10) ? 128'd0 : mdl[idx[9:0]];
      e.last = (b == int'(v.len));
      sbq.push_back(e);
      if (v.burst == 2'b01) idx++;
    end
    araddr = v.addr; arid = v.id; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < CYC) begin @(negedge clk); n++; end
    check("ar_wait", 128'(n < CYC), 128'(1));
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1; got = 0; first = 1'b1; stall = 1'b0; n = 0; s_data = '0; s_ctl = '0;
    while (got <= int'(v.len) && n < CYC) begin
      if (stall) begin
        check("r_stable_data", rdata, s_data);
        check("r_stable_ctl", 128'({rvalid, rresp, rlast, rid}), 128'(s_ctl));
      end
      if (rvalid && first) begin
        check("rd_first_lat", 128'(lat), 128'(2));
        first = 1'b0;
      end
      rready = v.toggle ? (n % 2 == 0) : 1'b1;
      if (rvalid && rready) begin
        e = sbq.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", 128'(rresp), 128'(e.resp));
        check("rlast", 128'(rlast), 128'(e.last));
        check("rid", 128'(rid), 128'(v.id));
        got++;
      end
      stall = rvalid && !rready;
      s_data = rdata;
      s_ctl = {rvalid, rresp, rlast, rid};
      @(negedge clk);
      n++;
      lat++;
    end
    rready = 1'b0;
    check("r_beats", 128'(got), 128'(int'(v.len) + 1));
    sbq.delete();
    check("arready_after_rlast", 128'(arready), 128'(1));
    check("rvalid_after_rlast", 128'(rvalid), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1, 64'h100, 8'd3, 4'd5, INCR, 3'd4, 128'hA0, 16'hFFFF, 4, 0, OKAY};
    vt[1]  = '{0, 64'h100, 8'd3, 4'd9, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[2]  = '{1, 64'h200, 8'd7, 4'd1, INCR, 3'd4, 128'h1000, 16'hFFFF, 8, 0, OKAY};
    vt[3]  = '{0, 64'h200, 8'd7, 4'd2, INCR, 3'd4, 128'h0, 16'h0, 0, 1, OKAY};
    vt[4]  = '{1, 64'h3FE0, 8'd3, 4'd3, INCR, 3'd4, 128'hB0, 16'hFFFF, 4, 0, SLVERR};
    vt[5]  = '{0, 64'h3FE0, 8'd3, 4'd4, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[6]  = '{1, 64'h100, 8'd3, 4'd6, WRAP, 3'd4, 128'hC0, 16'hFFFF, 4, 0, SLVERR};
    vt[7]  = '{1, 64'h100, 8'd3, 4'd6, INCR, 3'd3, 128'hD0, 16'hFFFF, 4, 0, SLVERR};
    vt[8]  = '{0, 64'h100, 8'd3, 4'd8, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[9]  = '{1, 64'h300, 8'd2, 4'hA, FIXED, 3'd4, 128'hE0, 16'hFFFF, 3, 0, OKAY};
    vt[10] = '{0, 64'h300, 8'd2, 4'd7, FIXED, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[11] = '{1, 64'h400, 8'd3, 4'hB, INCR, 3'd4, 128'hF0, 16'hFFFF, 2, 0, SLVERR};
    vt[12] = '{0, 64'h400, 8'd1, 4'hC, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[13] = '{0, 64'h1_0000_0100, 8'd1, 4'hD, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[14] = '{0, 64'h100, 8'd1, 4'hE, WRAP, 3'd4, 128'h0, 16'h0, 0, 0, OKAY};
    vt[15] = '{1, 64'h500, 8'd0, 4'd1, INCR, 3'd4, {128{1'b1}}, 16'hFFFF, 1, 0, OKAY};
    vt[16] = '{1, 64'h500, 8'd0, 4'd2, INCR, 3'd4, 128'h0, 16'h000F, 1, 0, OKAY};
    vt[17] = '{0, 64'h500, 8'd0, 4'd3, INCR, 3'd4, 128'h0, 16'h0, 0, 1, OKAY};

    rst = 1'b1;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_awready", 128'(awready), 128'(1));
    check("rst_arready", 128'(arready), 128'(1));
    check("rst_wready", 128'(wready), 128'(0));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_rlast", 128'(rlast), 128'(0));
    check("rst_ids_resps", 128'({bid, bresp, rid, rresp}), 128'(0));
    check("rst_rdata", rdata, 128'(0));

    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) do_write(vt[i]);
      else do_read(vt[i]);
    end

    // Reset while the second beat of a 4-beat write is on the bus.
    awaddr = 64'h600; awid = 4'd4; awlen = 8'd3; awsize = 3'd4; awburst = INCR; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 128'h55; wstrb = 16'hFFFF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge clk);
    wdata = 128'h56;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; wvalid = 1'b0;
    check("midrst_awready", 128'(awready), 128'(1));
    check("midrst_wready", 128'(wready), 128'(0));
    check("midrst_bvalid", 128'(bvalid), 128'(0));
    do_write('{1, 64'h600, 8'd3, 4'd4, INCR, 3'd4, 128'h660, 16'hFFFF, 4, 0, OKAY});
    do_read('{0, 64'h600, 8'd3, 4'd5, INCR, 3'd4, 128'h0, 16'h0, 0, 0, OKAY});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
